// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: reset PC default,
// NOP encoding, word size and the IF/ID fetch-entry layout.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;

    // One buffered fetch result as handed to IF/ID.
    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } fetch_entry_t;

    // What IF/ID sees when there is nothing valid to present.
    localparam fetch_entry_t BUBBLE_ENTRY = '{pc_plus4: 32'h0000_0000, instr: NOP_INSTR};

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~(WORD_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Two-entry instruction buffer between the imem response and IF/ID.
// Push/pop/flush in one cycle; flush wins. Head outputs read as a bubble
// (all zero) whenever the buffer is empty.
module if_fetch_fifo
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        push_i,
    input  logic [31:0] push_pc_plus4_i,
    input  logic [31:0] push_instr_i,
    input  logic        pop_i,
    output logic        head_valid_o,
    output logic [31:0] head_pc_plus4_o,
    output logic [31:0] head_instr_o,
    output logic [1:0]  occ_o
);

    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   occ_q, occ_d;
    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    fetch_entry_t head;

    // Next pointer, occupancy and storage contents.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which is what would infer a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        mem_d    = mem_q;

        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            occ_d    = 2'd0;
        end else begin
            if (push_i) begin
                // When full, wr_ptr == rd_ptr: the slot written is the one
                // being popped this same cycle, so the head is read first.
                mem_d[wr_ptr_q] = '{pc_plus4: push_pc_plus4_i, instr: push_instr_i};
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Control state, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its _d value from before the edge, regardless of order.
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately not reset; occupancy alone
        // decides validity and the head is masked to a bubble when empty.
        mem_q <= mem_d;
    end

    // Present the head, or a bubble when nothing is buffered.
    always_comb begin
        head = BUBBLE_ENTRY;
        if (occ_q != 2'd0) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign head_valid_o    = (occ_q != 2'd0);
    assign head_pc_plus4_o = head.pc_plus4;
    assign head_instr_o    = head.instr;
    assign occ_o           = occ_q;

    // The credit scheme upstream must never push into a full buffer
    // unless the head leaves in the same cycle.
    push_into_full_a: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !pop_i && !flush_i && (occ_q == 2'd2)));

    pop_from_empty_a: assert property (@(posedge clk) disable iff (rst)
        !(pop_i && !flush_i && (occ_q == 2'd0)));

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline. Owns the PC, issues word fetches
// over a req/ready + rvalid handshake, buffers responses in a 2-entry FIFO
// and presents {pc_plus4, instr, valid} to IF/ID. Redirects flush the path
// and discard a response still in flight.
// Optional: define IF_FETCH_PERF_EN to add perf_bubble_cnt_o, a saturating
// count of cycles in which IF/ID is written with a bubble.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_plus4_o,
    output logic [31:0] if_instr_o
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_bubble_cnt_o
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        outstanding_q, outstanding_d;
    logic        drop_pending_q, drop_pending_d;

    logic        fifo_valid;
    logic [1:0]  fifo_occ;
    logic [31:0] head_pc_plus4;
    logic [31:0] head_instr;

    logic        pop;
    logic        push;
    logic        req;
    logic        accept;
    logic [2:0]  credits_used;

    // Handshake decode: pop to IF/ID, push from imem, and whether a new
    // fetch fits in the buffer once everything in flight has landed.
    always_comb begin
        pop          = fifo_valid && !stall_i && !redirect_i;
        push         = imem_rvalid_i && !drop_pending_q && !redirect_i;
        credits_used = {1'b0, fifo_occ} + {2'b00, outstanding_q} - {2'b00, pop};
        req          = !rst && !redirect_i
                       && (!outstanding_q || imem_rvalid_i)
                       && (credits_used < 3'(BUF_DEPTH));
        accept       = req && imem_ready_i;
    end

    // Next PC, in-flight tracking and stale-response bookkeeping.
    always_comb begin
        pc_d           = pc_q;
        req_pc_d       = req_pc_q;
        outstanding_d  = outstanding_q;
        drop_pending_d = drop_pending_q;

        // A response always retires the single in-flight request; a new
        // accept in the same cycle immediately re-arms it.
        if (imem_rvalid_i) begin
            outstanding_d  = 1'b0;
            drop_pending_d = 1'b0;
        end
        if (accept) begin
            req_pc_d      = pc_q;
            pc_d          = pc_q + WORD_BYTES;
            outstanding_d = 1'b1;
        end

        if (redirect_i) begin
            pc_d = word_align(redirect_pc_i);
            // A request still waiting for its data must have that data
            // thrown away when it arrives; a response arriving right now is
            // already dropped because push is blocked.
            if (outstanding_q && !imem_rvalid_i) begin
                drop_pending_d = 1'b1;
            end
        end
    end

    // Fetch-control registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            req_pc_q       <= RESET_PC;
            outstanding_q  <= 1'b0;
            drop_pending_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            req_pc_q       <= req_pc_d;
            outstanding_q  <= outstanding_d;
            drop_pending_q <= drop_pending_d;
        end
    end

    if_fetch_fifo u_fifo (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (redirect_i),
        .push_i          (push),
        .push_pc_plus4_i (req_pc_q + WORD_BYTES),
        .push_instr_i    (imem_rdata_i),
        .pop_i           (pop),
        .head_valid_o    (fifo_valid),
        .head_pc_plus4_o (head_pc_plus4),
        .head_instr_o    (head_instr),
        .occ_o           (fifo_occ)
    );

    assign imem_req_o    = req;
    assign imem_addr_o   = pc_q;
    assign if_valid_o    = fifo_valid;
    assign if_pc_plus4_o = head_pc_plus4;
    assign if_instr_o    = head_instr;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    // Count bubble cycles written into IF/ID, saturating at all ones.
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (!fifo_valid && !stall_i && (perf_cnt_q != 32'hFFFF_FFFF)) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    // Bubble counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt_q <= 32'h0000_0000;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_bubble_cnt_o = perf_cnt_q;
`endif

    // The memory returns exactly one response per accepted request.
    rvalid_expected_a: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid_i |-> outstanding_q);

    // Fetch addresses are always word aligned.
    addr_aligned_a: assert property (@(posedge clk) disable iff (rst)
        imem_addr_o[1:0] == 2'b00);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit. A behavioural memory answers each
// accepted fetch after a chosen latency; the expected IF/ID stream is the
// sequential word sequence from the last reset/redirect target, and every
// fetch address is checked against the same sequential rule.
module tb_if_fetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_plus4_o;
    logic [31:0] if_instr_o;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_plus4_o (if_pc_plus4_o),
        .if_instr_o    (if_instr_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model: at most one request in flight.
    logic        pend_v;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          lat;

    // Stream model.
    logic [31:0] exp_pc;     // address of next instruction IF/ID should take
    logic [31:0] exp_fetch;  // address of next fetch the unit should issue
    int          pops;

    // Values sampled in the current cycle.
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc4;
    logic [31:0] s_instr;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h2008_0005;
        if (a == 32'h0000_0004) return 32'h2009_0003;
        return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    task automatic model_reset();
        pend_v    = 1'b0;
        pend_addr = 32'h0;
        pend_cnt  = 0;
        exp_pc    = 32'h0000_0000;
        exp_fetch = 32'h0000_0000;
    endtask

    // Drive one cycle's inputs (called just after a falling edge), sample
    // outputs, check them against the model and advance the model across
    // the coming rising edge.
    task automatic drive_and_check(input logic st, input logic rd,
                                   input logic [31:0] tgt, input logic rdy);
        logic        rv;
        logic        do_pop;
        logic [31:0] tgt_al;
        rv            = pend_v && (pend_cnt == 0);
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        imem_ready_i  = rdy;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_fn(pend_addr) : $urandom();
        #1;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_valid = if_valid_o;
        s_pc4   = if_pc_plus4_o;
        s_instr = if_instr_o;

        if (s_valid !== 1'b1) begin
            checks++;
            if (s_pc4 !== 32'h0 || s_instr !== 32'h0) begin
                errors++;
                $display("FAIL bubble_zero: pc_plus4=%h instr=%h required 0/0", s_pc4, s_instr);
            end
        end

        do_pop = (s_valid === 1'b1) && !st && !rd;
        if (do_pop) begin
            checks++;
            if (s_pc4 !== exp_pc + 32'd4 || s_instr !== mem_fn(exp_pc)) begin
                errors++;
                $display("FAIL stream_order: got pc_plus4=%h instr=%h required %h/%h",
                         s_pc4, s_instr, exp_pc + 32'd4, mem_fn(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            pops++;
        end

        if (rd) begin
            checks++;
            if (s_req !== 1'b0) begin
                errors++;
                $display("FAIL redirect_no_req: req=%b required 0", s_req);
            end
        end else if (s_req === 1'b1) begin
            checks++;
            if (s_addr !== exp_fetch) begin
                errors++;
                $display("FAIL fetch_addr: addr=%h required %h", s_addr, exp_fetch);
            end
        end

        checks++;
        if (s_req === 1'b1 && pend_v && !rv) begin
            errors++;
            $display("FAIL single_outstanding: req=1 while response pending for %h", pend_addr);
        end

        // Model state across the rising edge.
        if (rv) pend_v = 1'b0;
        else if (pend_v) pend_cnt--;
        if (s_req === 1'b1 && rdy && !rd) begin
            pend_v    = 1'b1;
            pend_addr = s_addr;
            pend_cnt  = lat - 1;
            exp_fetch = exp_fetch + 32'd4;
        end
        if (rd) begin
            tgt_al    = tgt & 32'hFFFF_FFFC;
            exp_pc    = tgt_al;
            exp_fetch = tgt_al;
        end
    endtask

    task automatic step(input logic st, input logic rd, input logic [31:0] tgt, input logic rdy);
        @(negedge clk);
        drive_and_check(st, rd, tgt, rdy);
    endtask

    task automatic wait_first_valid(input logic [31:0] exp_pc4);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (s_valid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (s_pc4 !== exp_pc4) begin
                    errors++;
                    $display("FAIL first_valid: pc_plus4=%h required %h", s_pc4, exp_pc4);
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL first_valid_timeout: valid=0 required 1 within 30 cycles");
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0 ||
            if_pc_plus4_o !== 32'h0 || if_instr_o !== 32'h0) begin
            errors++;
            $display("FAIL %s: req=%b valid=%b pc_plus4=%h instr=%h required all 0",
                     name, imem_req_o, if_valid_o, if_pc_plus4_o, if_instr_o);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_ready_i  = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        model_reset();
        pops = 0;
        lat  = 1;
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset_outputs");
    endtask

    task automatic test_back_to_back();
        lat = 1;
        @(negedge clk);
        rst = 1'b0;
        drive_and_check(1'b0, 1'b0, 32'h0, 1'b1);        // cycle 0
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h required 1/00000000", s_req, s_addr);
        end
        checks++;
        if (s_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_cycle0: valid=%b required 0", s_valid);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);                   // cycle 1
        checks++;
        if (s_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_cycle1: valid=%b required 0", s_valid);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);                   // cycle 2
        checks++;
        if (s_valid !== 1'b1 || s_pc4 !== 32'h4 || s_instr !== 32'h2008_0005) begin
            errors++;
            $display("FAIL valid_cycle2: valid=%b pc_plus4=%h instr=%h required 1/00000004/20080005",
                     s_valid, s_pc4, s_instr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);                   // cycle 3
        checks++;
        if (s_valid !== 1'b1 || s_pc4 !== 32'h8 || s_instr !== 32'h2009_0003) begin
            errors++;
            $display("FAIL valid_cycle3: valid=%b pc_plus4=%h instr=%h required 1/00000008/20090003",
                     s_valid, s_pc4, s_instr);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if (s_valid !== 1'b1 || s_req !== 1'b1) begin
                errors++;
                $display("FAIL sustained: valid=%b req=%b required 1/1", s_valid, s_req);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_pc4;
        logic [31:0] held_instr;
        lat = 1;
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            if (i == 0) begin
                held_pc4   = s_pc4;
                held_instr = s_instr;
                checks++;
                if (s_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_valid: valid=%b required 1", s_valid);
                end
            end else begin
                checks++;
                if (s_valid !== 1'b1 || s_pc4 !== held_pc4 || s_instr !== held_instr) begin
                    errors++;
                    $display("FAIL stall_hold: pc_plus4=%h instr=%h required %h/%h",
                             s_pc4, s_instr, held_pc4, held_instr);
                end
                checks++;
                if (s_req !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_credit: req=%b required 0", s_req);
                end
            end
        end
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_ready_low();
        logic [31:0] held_addr;
        lat = 1;
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (i == 0) held_addr = s_addr;
            checks++;
            if (s_req !== 1'b1 || s_addr !== held_addr) begin
                errors++;
                $display("FAIL ready_low_hold: req=%b addr=%h required 1/%h", s_req, s_addr, held_addr);
            end
        end
        checks++;
        if (s_valid !== 1'b0 || s_pc4 !== 32'h0 || s_instr !== 32'h0) begin
            errors++;
            $display("FAIL ready_low_drain: valid=%b pc_plus4=%h instr=%h required 0/0/0",
                     s_valid, s_pc4, s_instr);
        end
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_redirect_outstanding();
        bit found = 1'b0;
        lat = 3;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (pend_v && pend_cnt == 2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL redir_setup_timeout: no fetch accepted within 20 cycles");
        end
        step(1'b0, 1'b1, 32'h0000_0040, 1'b1);           // redirect, response 2 cycles away
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (s_req !== 1'b0 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait: req=%b valid=%b required 0/0", s_req, s_valid);
        end
        lat = 1;
        step(1'b0, 1'b0, 32'h0, 1'b1);                   // stale response arrives
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_0040 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_drop_issue: req=%b addr=%h valid=%b required 1/00000040/0",
                     s_req, s_addr, s_valid);
        end
        wait_first_valid(32'h0000_0044);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_redirect_rvalid();
        bit found = 1'b0;
        lat = 2;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (pend_v && pend_cnt == 0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL redir_rv_setup_timeout: no response due within 20 cycles");
        end
        lat = 1;
        step(1'b0, 1'b1, 32'h0000_0041, 1'b1);           // redirect with rvalid, unaligned target
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_0040) begin
            errors++;
            $display("FAIL redir_rv_next_req: req=%b addr=%h required 1/00000040", s_req, s_addr);
        end
        wait_first_valid(32'h0000_0044);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_reset_mid();
        lat = 3;
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (s_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup: valid=%b required 1", s_valid);
        end
        @(posedge clk);
        #3;
        rst           = 1'b1;
        imem_ready_i  = 1'b0;
        imem_rvalid_i = 1'b0;
        stall_i       = 1'b0;
        #1;
        check_outputs_zero("reset_mid_outputs");
        model_reset();
        repeat (2) @(negedge clk);
        lat = 1;
        @(negedge clk);
        rst = 1'b0;
        drive_and_check(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_mid_first_addr: req=%b addr=%h required 1/00000000", s_req, s_addr);
        end
        wait_first_valid(32'h0000_0004);
    endtask

    task automatic test_random();
        int          pops_start;
        logic        st;
        logic        rd;
        logic        rdy;
        logic [31:0] tgt;
        pops_start = pops;
        for (int i = 0; i < 1500; i++) begin
            lat = int'($urandom_range(1, 4));
            st  = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           tgt = $urandom() & 32'h0000_FFFF;
            step(st, rd, tgt, rdy);
        end
        lat = 1;
        repeat (20) step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (pops - pops_start < 100) begin
            errors++;
            $display("FAIL random_progress: %0d instructions delivered, required at least 100",
                     pops - pops_start);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_ready_low();
        test_redirect_outstanding();
        test_redirect_rvalid();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
IF stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. Owns the PC and issues word fetches to instruction memory over a req/ready + rvalid handshake. Buffers returned instructions in a 2-entry FIFO and presents {pc_plus4, instr} with a valid flag to IF/ID. Handles hazard-unit stalls and branch/jump redirects, discarding stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BUF_DEPTH, 2, instruction buffer depth; fixed at 2, no other value supported.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
stall_i  in  1  hazard unit: hold the IF/ID output (IF/ID write_en = !stall_i).
redirect_i  in  1  taken branch/jump; flush the fetch path.
redirect_pc_i  in  32  redirect target.
imem_req_o  out  1  fetch request.
imem_addr_o  out  32  fetch address, word aligned.
imem_ready_i  in  1  memory accepts request when req & ready.
imem_rvalid_i  in  1  response valid; exactly one per accepted request, at least 1 cycle after acceptance.
imem_rdata_i  in  32  instruction word.
if_valid_o  out  1  buffer head valid; IF/ID loads bubble (instr 0) when low.
if_pc_plus4_o  out  32  head PC+4; 0 when !if_valid_o.
if_instr_o  out  32  head instruction; 0 when !if_valid_o.

Behaviour:
- Reset (async): pc_q=RESET_PC, FIFO empty (occ=0), outstanding=0, drop_pending=0. Outputs: imem_req_o=0 while rst high, if_valid_o=0, if_pc_plus4_o=0, if_instr_o=0. Reset mid-transaction abandons the outstanding request. Memory must not deliver its response after reset.
- pop = if_valid_o & !stall_i & !redirect_i. pop removes the FIFO head at the clock edge.
- Issue condition: imem_req_o = !redirect_i & (!outstanding | imem_rvalid_i) & (occ + outstanding - pop < 2). imem_addr_o = pc_q.
- On accept (req & ready): req_pc_q <= pc_q, pc_q <= pc_q + 4 (mod 2^32 wrap), outstanding <= 1.
- On imem_rvalid_i with !drop_pending & !redirect_i: push {req_pc_q+4, imem_rdata_i}. outstanding clears unless a new request is accepted in the same cycle. Credit rule guarantees no overflow. Push to a full FIFO is an assertion failure.
- Back-to-back: with ready=1 and 1-cycle response latency, one instruction per cycle is sustained. First if_valid_o occurs 2 cycles after reset release.
- Redirect (priority over stall and pop):
  - FIFO flushed (occ<=0).
  - pc_q <= {redirect_pc_i[31:2],2'b00}.
  - No request issued this cycle.
  - If outstanding & !imem_rvalid_i: drop_pending<=1. Any rvalid in the redirect cycle is discarded.
- drop_pending: the next rvalid is discarded and clears drop_pending. A new request may issue in that same cycle. A repeated redirect while drop_pending updates pc_q only.
- Stall: FIFO head held stable. Fetching continues until credits are exhausted (occ=2).
- Simultaneous push and pop on a full FIFO is legal; occ stays unchanged.

Optional Feature:
Macro IF_FETCH_PERF_EN.
- Defined: adds output perf_bubble_cnt_o [31:0], reset 0. Increments (saturating at 32'hFFFF_FFFF) each cycle !if_valid_o & !stall_i & !rst.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg: RESET_PC default, NOP_INSTR=32'h0000_0000, WORD_BYTES=4, fetch-entry typedef {pc_plus4[31:0], instr[31:0]}.
- One sub-module: if_fetch_fifo (2-entry FIFO with push/pop/flush, occ output, head data).

Test Plan:
- Reset release, ready=1, 1-cycle rvalid returning 32'h2008_0005, 32'h2009_0003 -> req addr 0x0 at cycle 0. if_valid_o=1 from cycle 2 with pc_plus4=0x4 then 0x8, one per cycle.
- stall_i high 4 cycles at steady state -> head frozen; requests stop once occ=2. On release, instructions resume in order with none lost or duplicated.
- redirect_i with redirect_pc_i=0x0000_0040 while a request is outstanding (rvalid 2 cycles later) -> late response discarded, FIFO flushed, next req addr 0x40, next valid pc_plus4=0x44.
- redirect_i coincident with rvalid -> response dropped, drop_pending stays 0, next req 0x40 the following cycle.
- imem_ready_i low 3 cycles -> req/addr held stable, if_valid_o falls to 0 after FIFO drains, instr/pc_plus4 outputs 0.
- rst asserted mid-WAIT with occ=2 -> all outputs 0 immediately. After release, first addr is RESET_PC.
